// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, flush bubble and a saturating stall counter; optional writeback forwarding into held operands under ID_EX_STALL_FWD_EN.
// Latency: one cycle from in_* to ex_*, all outputs registered, no combinational input-to-output path.
// Backpressure: stall holds contents; flush overrides stall and loads a bubble.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [0:5]        in_op,
  input  logic [0:5]        in_func,
  input  logic [1:0]        in_execute_ctr,
  input  logic              in_mux_select,
  input  logic [0:DATA_W-1] in_rs_data,
  input  logic [0:DATA_W-1] in_rt_data,
  input  logic [0:15]       in_imm,
  input  logic [4:0]        in_rs_addr,
  input  logic [4:0]        in_rt_addr,
  input  logic [4:0]        in_rd_addr,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [0:DATA_W-1] wb_data,
  output logic              ex_valid,
  output logic [0:5]        ex_op,
  output logic [0:5]        ex_func,
  output logic [1:0]        ex_execute_ctr,
  output logic              ex_mux_select,
  output logic [0:DATA_W-1] ex_rs_data,
  output logic [0:DATA_W-1] ex_rt_data,
  output logic [0:DATA_W-1] ex_imm_ext,
  output logic [4:0]        ex_rs_addr,
  output logic [4:0]        ex_rt_addr,
  output logic [4:0]        ex_rd_addr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t            state, state_nxt;
  logic              in_hold;
  logic [0:DATA_W-1] imm_ext;

  // Bit 0 is the MSB, so in_imm[0] is the sign bit.
  assign imm_ext = {{(DATA_W-16){in_imm[0]}}, in_imm};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_hold   = 1'b0;
    case (state)
      RUN: begin
        if (stall && !flush) state_nxt = HOLD;
      end
      HOLD: begin
        in_hold = 1'b1;
        if (!stall || flush) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ex_valid       <= 1'b0;
      ex_op          <= '0;
      ex_func        <= '0;
      ex_execute_ctr <= '0;
      ex_mux_select  <= 1'b0;
      ex_rs_data     <= '0;
      ex_rt_data     <= '0;
      ex_imm_ext     <= '0;
      ex_rs_addr     <= '0;
      ex_rt_addr     <= '0;
      ex_rd_addr     <= '0;
    end else if (flush) begin
      ex_valid       <= 1'b0;
      ex_op          <= '0;
      ex_func        <= '0;
      ex_execute_ctr <= '0;
      ex_mux_select  <= 1'b0;
      ex_rs_data     <= '0;
      ex_rt_data     <= '0;
      ex_imm_ext     <= '0;
      ex_rs_addr     <= '0;
      ex_rt_addr     <= '0;
      ex_rd_addr     <= '0;
    end else if (!stall) begin
      ex_valid       <= in_valid;
      ex_op          <= in_op;
      ex_func        <= in_func;
      ex_execute_ctr <= in_execute_ctr;
      ex_mux_select  <= in_mux_select;
      ex_rs_data     <= in_rs_data;
      ex_rt_data     <= in_rt_data;
      ex_imm_ext     <= imm_ext;
      ex_rs_addr     <= in_rs_addr;
      ex_rt_addr     <= in_rt_addr;
      ex_rd_addr     <= in_rd_addr;
    end else begin
`ifdef ID_EX_STALL_FWD_EN
      // A held instruction picks up results retiring while it waits.
      if (in_hold && ex_valid && wb_we && (wb_addr != 5'd0)) begin
        if (wb_addr == ex_rs_addr) ex_rs_data <= wb_data;
        if (wb_addr == ex_rt_addr) ex_rt_data <= wb_data;
      end
`endif
    end
  end

`ifndef ID_EX_STALL_FWD_EN
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_addr, wb_data, in_hold};
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt <= '0;
    end else if (stall && !flush && ex_valid && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed vector bench for id_ex_pipe_reg plus sequences for async reset, counter saturation and stall forwarding.
module tb_id_ex_pipe_reg;

  logic        clk, nrst, stall, flush, in_valid;
  logic [0:5]  in_op, in_func;
  logic [1:0]  in_execute_ctr;
  logic        in_mux_select;
  logic [0:31] in_rs_data, in_rt_data;
  logic [0:15] in_imm;
  logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [0:31] wb_data;
  logic        ex_valid;
  logic [0:5]  ex_op, ex_func;
  logic [1:0]  ex_execute_ctr;
  logic        ex_mux_select;
  logic [0:31] ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;
  logic [7:0]  stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  id_ex_pipe_reg #(.DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .nrst(nrst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_op(in_op), .in_func(in_func), .in_execute_ctr(in_execute_ctr),
    .in_mux_select(in_mux_select), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rd_addr(in_rd_addr), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_func(ex_func),
    .ex_execute_ctr(ex_execute_ctr), .ex_mux_select(ex_mux_select),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, vld;
    logic [5:0]  op, func;
    logic [1:0]  ctr;
    logic        mux;
    logic [31:0] rs, rt;
    logic [15:0] imm;
    logic [4:0]  rsa, rta, rda;
    logic        e_vld;
    logic [5:0]  e_op, e_func;
    logic [1:0]  e_ctr;
    logic        e_mux;
    logic [31:0] e_rs, e_rt, e_imm;
    logic [4:0]  e_rsa, e_rta, e_rda;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; flush = v.flush; in_valid = v.vld;
    in_op = v.op; in_func = v.func; in_execute_ctr = v.ctr; in_mux_select = v.mux;
    in_rs_data = v.rs; in_rt_data = v.rt; in_imm = v.imm;
    in_rs_addr = v.rsa; in_rt_addr = v.rta; in_rd_addr = v.rda;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d.valid", i), 64'(ex_valid),       64'(v.e_vld));
    chk($sformatf("v%0d.op", i),    64'(ex_op),          64'(v.e_op));
    chk($sformatf("v%0d.func", i),  64'(ex_func),        64'(v.e_func));
    chk($sformatf("v%0d.ctr", i),   64'(ex_execute_ctr), 64'(v.e_ctr));
    chk($sformatf("v%0d.mux", i),   64'(ex_mux_select),  64'(v.e_mux));
    chk($sformatf("v%0d.rs", i),    64'(ex_rs_data),     64'(v.e_rs));
    chk($sformatf("v%0d.rt", i),    64'(ex_rt_data),     64'(v.e_rt));
    chk($sformatf("v%0d.imm", i),   64'(ex_imm_ext),     64'(v.e_imm));
    chk($sformatf("v%0d.rsa", i),   64'(ex_rs_addr),     64'(v.e_rsa));
    chk($sformatf("v%0d.rta", i),   64'(ex_rt_addr),     64'(v.e_rta));
    chk($sformatf("v%0d.rda", i),   64'(ex_rd_addr),     64'(v.e_rda));
    chk($sformatf("v%0d.cnt", i),   64'(stall_cnt),      64'(v.e_cnt));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".valid"}, 64'(ex_valid), 64'd0);
    chk({tag, ".op"},    64'(ex_op), 64'd0);
    chk({tag, ".func"},  64'(ex_func), 64'd0);
    chk({tag, ".ctr"},   64'(ex_execute_ctr), 64'd0);
    chk({tag, ".mux"},   64'(ex_mux_select), 64'd0);
    chk({tag, ".rs"},    64'(ex_rs_data), 64'd0);
    chk({tag, ".rt"},    64'(ex_rt_data), 64'd0);
    chk({tag, ".imm"},   64'(ex_imm_ext), 64'd0);
    chk({tag, ".addr"},  64'({ex_rs_addr, ex_rt_addr, ex_rd_addr}), 64'd0);
    chk({tag, ".cnt"},   64'(stall_cnt), 64'd0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] fwd_exp;

    // stall flush vld op func ctr mux rs rt imm rsa rta rda | expected ex_* ... stall_cnt
    vecs[0] = '{1'b0,1'b0,1'b1,6'h0D,6'h20,2'd1,1'b0,32'h11111111,32'h22222222,16'h8001,5'd1,5'd2,5'd3,
                1'b1,6'h0D,6'h20,2'd1,1'b0,32'h11111111,32'h22222222,32'hFFFF8001,5'd1,5'd2,5'd3,8'd0};
    vecs[1] = '{1'b0,1'b0,1'b1,6'h23,6'h00,2'd2,1'b1,32'h0000000A,32'h0000000B,16'h7FFF,5'd4,5'd5,5'd6,
                1'b1,6'h23,6'h00,2'd2,1'b1,32'h0000000A,32'h0000000B,32'h00007FFF,5'd4,5'd5,5'd6,8'd0};
    vecs[2] = '{1'b1,1'b0,1'b1,6'h3F,6'h3F,2'd3,1'b0,32'hCCCCCCCC,32'hDDDDDDDD,16'hFFFF,5'd7,5'd8,5'd9,
                1'b1,6'h23,6'h00,2'd2,1'b1,32'h0000000A,32'h0000000B,32'h00007FFF,5'd4,5'd5,5'd6,8'd1};
    vecs[3] = '{1'b1,1'b0,1'b0,6'h01,6'h02,2'd0,1'b1,32'h00000001,32'h00000002,16'h1234,5'd10,5'd11,5'd12,
                1'b1,6'h23,6'h00,2'd2,1'b1,32'h0000000A,32'h0000000B,32'h00007FFF,5'd4,5'd5,5'd6,8'd2};
    vecs[4] = '{1'b1,1'b0,1'b1,6'h15,6'h2A,2'd1,1'b1,32'h00000003,32'h00000004,16'h8000,5'd13,5'd14,5'd15,
                1'b1,6'h23,6'h00,2'd2,1'b1,32'h0000000A,32'h0000000B,32'h00007FFF,5'd4,5'd5,5'd6,8'd3};
    vecs[5] = '{1'b1,1'b1,1'b1,6'h3F,6'h3F,2'd3,1'b1,32'hFFFFFFFF,32'hFFFFFFFF,16'hFFFF,5'd31,5'd31,5'd31,
                1'b0,6'h00,6'h00,2'd0,1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,8'd3};
    vecs[6] = '{1'b1,1'b0,1'b1,6'h0D,6'h20,2'd2,1'b1,32'h00000005,32'h00000006,16'h9000,5'd1,5'd2,5'd3,
                1'b0,6'h00,6'h00,2'd0,1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,8'd3};
    vecs[7] = '{1'b0,1'b0,1'b0,6'h2A,6'h15,2'd1,1'b1,32'h00000005,32'h00000006,16'h0001,5'd7,5'd8,5'd9,
                1'b0,6'h2A,6'h15,2'd1,1'b1,32'h00000005,32'h00000006,32'h00000001,5'd7,5'd8,5'd9,8'd3};
    vecs[8] = '{1'b0,1'b1,1'b1,6'h0D,6'h20,2'd3,1'b1,32'h00000077,32'h00000088,16'hFFFE,5'd1,5'd2,5'd3,
                1'b0,6'h00,6'h00,2'd0,1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,8'd3};
    vecs[9] = '{1'b0,1'b0,1'b1,6'h0D,6'h31,2'd1,1'b0,32'hDEADBEEF,32'h0BADF00D,16'hC000,5'd16,5'd17,5'd18,
                1'b1,6'h0D,6'h31,2'd1,1'b0,32'hDEADBEEF,32'h0BADF00D,32'hFFFFC000,5'd16,5'd17,5'd18,8'd3};

    nrst = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    drive(vecs[0]);
    #1;
    check_all_zero("reset");
    #2 nrst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      check_vec(i, vecs[i]);
    end

    // Asynchronous reset mid-cycle with a valid instruction held
    stall = 1'b0; flush = 1'b0;
    #2 nrst = 1'b0;
    #1;
    check_all_zero("async_rst");
    #1 nrst = 1'b1;

    // Counter saturation over 300 stalled cycles
    v = vecs[0];
    drive(v);
    @(posedge clk); #1;
    chk("sat.load_valid", 64'(ex_valid), 64'd1);
    stall = 1'b1;
    in_op = 6'h3F;
    repeat (254) @(posedge clk);
    #1;
    chk("sat.cnt254", 64'(stall_cnt), 64'hFE);
    repeat (46) @(posedge clk);
    #1;
    chk("sat.cnt255", 64'(stall_cnt), 64'hFF);
    chk("sat.op_held", 64'(ex_op), 64'h0D);

    // Writeback into held operands
    stall = 1'b0;
    in_valid = 1'b1; in_rs_addr = 5'd5; in_rt_addr = 5'd5;
    in_rs_data = 32'h00000001; in_rt_data = 32'h00000002;
    @(posedge clk); #1;
    stall = 1'b1; wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h12345678;
    @(posedge clk); #1;
    chk("fwd.first_stall_rs", 64'(ex_rs_data), 64'h1);
    wb_addr = 5'd0;
    @(posedge clk); #1;
    chk("fwd.addr0_rs", 64'(ex_rs_data), 64'h1);
    chk("fwd.addr0_rt", 64'(ex_rt_data), 64'h2);
    wb_addr = 5'd5;
    @(posedge clk); #1;
`ifdef ID_EX_STALL_FWD_EN
    fwd_exp = 32'h12345678;
    chk("fwd.rs", 64'(ex_rs_data), 64'(fwd_exp));
    chk("fwd.rt", 64'(ex_rt_data), 64'(fwd_exp));
`else
    fwd_exp = 32'h00000001;
    chk("fwd.rs", 64'(ex_rs_data), 64'(fwd_exp));
    chk("fwd.rt", 64'(ex_rt_data), 64'h2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
